// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - end-of-test monitor snooping register-file write-back
//
// Tracks the test-convention registers (end flag, result, test number) from the
// write-back port and runs a cycle watchdog, presenting sticky completion status.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   wb_en           register-file write enable (same cycle as the core's write)
//   wb_addr         destination register index
//   wb_data         write data
//   done            test finished (pass, fail or timeout), sticky
//   pass / fail     verdict from the result register, sticky
//   timeout         watchdog expired before the end flag, sticky
//   fail_testnum    test-number shadow frozen at completion
//   cycle_count     cycles spent in RUN, frozen at completion
module riscv_test_monitor #(
    parameter int CPU_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int END_REG        = 26,
    parameter int RESULT_REG     = 27,
    parameter int TESTNUM_REG    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [CPU_WIDTH-1:0] wb_data,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [CPU_WIDTH-1:0] fail_testnum,
    output logic [31:0]          cycle_count
);

    localparam logic [4:0]  END_IDX  = 5'(END_REG);
    localparam logic [4:0]  RES_IDX  = 5'(RESULT_REG);
    localparam logic [4:0]  TNUM_IDX = 5'(TESTNUM_REG);
    localparam logic [31:0] TERM_CNT = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CPU_WIDTH-1:0] ONE = CPU_WIDTH'(1);

    typedef enum logic [1:0] {RUN, SETTLE, DONE_ST} state_e;

    state_e state_q, state_d;

    logic [CPU_WIDTH-1:0] sh_end_q, sh_end_d;
    logic [CPU_WIDTH-1:0] sh_res_q, sh_res_d;
    logic [CPU_WIDTH-1:0] sh_tnum_q, sh_tnum_d;

    logic done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [CPU_WIDTH-1:0] fail_testnum_q, fail_testnum_d;
    logic [31:0]          cycle_count_q, cycle_count_d;

    // x0 is never a real destination, so index 0 matches nothing even if a
    // parameter is set to 0. Aliased parameters each load independently.
    logic wr_valid, ld_end, ld_res, ld_tnum, end_hit, term_hit;
    logic [CPU_WIDTH-1:0] res_fwd, tnum_fwd;

    always_comb begin
        wr_valid  = wb_en && (wb_addr != 5'd0);
        ld_end    = wr_valid && (wb_addr == END_IDX);
        ld_res    = wr_valid && (wb_addr == RES_IDX);
        ld_tnum   = wr_valid && (wb_addr == TNUM_IDX);
        sh_end_d  = ld_end  ? wb_data : sh_end_q;
        sh_res_d  = ld_res  ? wb_data : sh_res_q;
        sh_tnum_d = ld_tnum ? wb_data : sh_tnum_q;
        // Only a write of exactly 1 ends the test; other values just update the shadow.
        end_hit   = ld_end && (sh_end_d == ONE);
        term_hit  = (cycle_count_q == TERM_CNT);
        // A write landing in SETTLE is forwarded so a trailing result still counts.
        res_fwd   = sh_res_d;
        tnum_fwd  = sh_tnum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_end_q  <= '0;
            sh_res_q  <= '0;
            sh_tnum_q <= '0;
        end else begin
            sh_end_q  <= sh_end_d;
            sh_res_q  <= sh_res_d;
            sh_tnum_q <= sh_tnum_d;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            fail_testnum_q <= '0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            timeout_q      <= timeout_d;
            fail_testnum_q <= fail_testnum_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    // Next state; the end write takes priority over the watchdog terminal count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (end_hit)       state_d = SETTLE;
                else if (term_hit) state_d = DONE_ST;
            end
            SETTLE:  state_d = DONE_ST;
            DONE_ST: state_d = DONE_ST;
            default: state_d = RUN;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        done_d         = done_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        timeout_d      = timeout_q;
        fail_testnum_d = fail_testnum_q;
        cycle_count_d  = cycle_count_q;
        case (state_q)
            RUN: begin
                if (!end_hit && term_hit) begin
                    done_d         = 1'b1;
                    timeout_d      = 1'b1;
                    fail_testnum_d = tnum_fwd;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            SETTLE: begin
                done_d         = 1'b1;
                pass_d         = (res_fwd == ONE);
                fail_d         = (res_fwd != ONE);
                fail_testnum_d = tnum_fwd;
            end
            default: ;
        endcase
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign fail_testnum = fail_testnum_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - directed vector bench for riscv_test_monitor
module tb_riscv_test_monitor;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycle_count;

    int checks;
    int errors;

    riscv_test_monitor #(
        .CPU_WIDTH      (32),
        .TIMEOUT_CYCLES (20),
        .END_REG        (26),
        .RESULT_REG     (27),
        .TESTNUM_REG    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {done, pass, fail, timeout}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_PASS = 4'b1100;
    localparam logic [3:0] F_FAIL = 4'b1010;
    localparam logic [3:0] F_TO   = 4'b1001;

    typedef struct {
        logic        r;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [31:0] tnum;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic en, input logic [4:0] addr,
                       input logic [31:0] data, input logic [3:0] flags,
                       input logic [31:0] tnum, input logic [31:0] cnt);
        vec_t v;
        v.r = r; v.en = en; v.addr = addr; v.data = data;
        v.flags = flags; v.tnum = tnum; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 ns past the edge.
    task automatic step(input logic r, input logic en, input logic [4:0] a, input logic [31:0] d);
        rst = r; wb_en = en; wb_addr = a; wb_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] flags,
                             input logic [31:0] tnum, input logic [31:0] cnt);
        check({name, ".flags"}, {28'd0, done, pass, fail, timeout}, {28'd0, flags});
        check({name, ".tnum"}, fail_testnum, tnum);
        check({name, ".cnt"}, cycle_count, cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;

        // Pass sequence
        add(1, 0, 0, 0, F_NONE, 0, 0);
        add(0, 1, 3, 5, F_NONE, 0, 1);
        add(0, 1, 27, 1, F_NONE, 0, 2);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, F_NONE, 0, 32'(3 + i));
        add(0, 1, 26, 1, F_NONE, 0, 13);
        add(0, 0, 0, 0, F_PASS, 5, 13);
        add(0, 1, 27, 0, F_PASS, 5, 13);
        // Fail sequence; later writes in DONE change nothing
        add(1, 0, 0, 0, F_NONE, 0, 0);
        add(0, 1, 3, 7, F_NONE, 0, 1);
        add(0, 1, 27, 0, F_NONE, 0, 2);
        add(0, 1, 26, 1, F_NONE, 0, 3);
        add(0, 0, 0, 0, F_FAIL, 7, 3);
        add(0, 1, 27, 1, F_FAIL, 7, 3);
        add(0, 1, 3, 9, F_FAIL, 7, 3);
        // x0 write ignored, x26=2 does not end, result shadow cleared by reset
        add(1, 0, 0, 0, F_NONE, 0, 0);
        add(0, 1, 0, 1, F_NONE, 0, 1);
        add(0, 1, 26, 2, F_NONE, 0, 2);
        add(0, 0, 0, 0, F_NONE, 0, 3);
        add(0, 1, 3, 4, F_NONE, 0, 4);
        add(0, 1, 26, 1, F_NONE, 0, 5);
        add(0, 0, 0, 0, F_FAIL, 4, 5);
        // Reset in SETTLE (overriding an end write), then a clean pass, then reset in DONE
        add(1, 0, 0, 0, F_NONE, 0, 0);
        add(0, 1, 27, 1, F_NONE, 0, 1);
        add(0, 1, 26, 1, F_NONE, 0, 2);
        add(1, 1, 26, 1, F_NONE, 0, 0);
        add(0, 1, 3, 6, F_NONE, 0, 1);
        add(0, 1, 27, 1, F_NONE, 0, 2);
        add(0, 1, 26, 1, F_NONE, 0, 3);
        add(0, 0, 0, 0, F_PASS, 6, 3);
        add(1, 0, 0, 0, F_NONE, 0, 0);
        add(0, 1, 27, 1, F_NONE, 0, 1);
        add(0, 1, 3, 8, F_NONE, 0, 2);
        add(0, 1, 26, 1, F_NONE, 0, 3);
        add(0, 0, 0, 0, F_PASS, 8, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].en, vecs[i].addr, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].tnum, vecs[i].cnt);
        end

        // Trailing result written in the SETTLE cycle
        step(1, 0, 0, 0);
        step(0, 1, 3, 12);
        step(0, 1, 26, 1);
        check_all("trail_res.settle", F_NONE, 0, 2);
        step(0, 1, 27, 1);
        check_all("trail_res.done", F_PASS, 12, 2);

        // Trailing test number written in the SETTLE cycle
        step(1, 0, 0, 0);
        step(0, 1, 27, 1);
        step(0, 1, 3, 3);
        step(0, 1, 26, 1);
        step(0, 1, 3, 12);
        check_all("trail_tnum", F_PASS, 12, 3);

        // Watchdog timeout after 20 edges from reset release
        step(1, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0);
        check_all("timeout.pre", F_NONE, 0, 19);
        step(0, 0, 0, 0);
        check_all("timeout.hit", F_TO, 0, 19);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check_all("timeout.hold", F_TO, 0, 19);

        // End write coinciding with the terminal count: verdict, not timeout
        step(1, 0, 0, 0);
        step(0, 1, 27, 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0);
        check_all("coinc.pre", F_NONE, 0, 19);
        step(0, 1, 26, 1);
        check_all("coinc.settle", F_NONE, 0, 20);
        step(0, 0, 0, 0);
        check_all("coinc.done", F_PASS, 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
